// File: rtl/minisys_pkg.sv
// Shared encodings for the load/store path: access opcodes, error codes,
// sequencer states and small opcode classification helpers.
package minisys_pkg;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LBU = 3'd1,
    OP_LH  = 3'd2,
    OP_LHU = 3'd3,
    OP_LW  = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } op_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ALIGN   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  function automatic logic is_store(input logic [2:0] op);
    case (op)
      OP_SB, OP_SH, OP_SW: is_store = 1'b1;
      default:             is_store = 1'b0;
    endcase
  endfunction

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
    case (op)
      OP_LH, OP_LHU, OP_SH: is_misaligned = addr_lo[0];
      OP_LW, OP_SW:         is_misaligned = (addr_lo != 2'b00);
      default:              is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword lane of a memory word and applies
// sign or zero extension according to the load opcode.
module load_align (
  input  logic [31:0] rdata,
  input  logic [2:0]  op,
  input  logic [1:0]  addr_lo,
  output logic [31:0] result
);
  import minisys_pkg::*;

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane shift followed by extension of the selected field.
  always_comb begin
    byte_s = 8'(rdata >> {addr_lo, 3'b000});
    half_s = 16'(rdata >> {addr_lo[1], 4'b0000});
    case (op)
      OP_LB:   result = {{24{byte_s[7]}}, byte_s};
      OP_LBU:  result = {24'd0, byte_s};
      OP_LH:   result = {{16{half_s[15]}}, half_s};
      OP_LHU:  result = {16'd0, half_s};
      OP_LW:   result = rdata;
      default: result = 32'd0;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer: accepts one access at a time, checks alignment, runs the
// word-aligned memory handshake with a wait timeout and returns extended load data.
module mem_access_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  import minisys_pkg::*;

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e          state_r;
  logic [2:0]      op_r;
  logic [1:0]      addr_lo_r;
  logic [CW-1:0]   cnt_r;
  logic [3:0]      be_s;
  logic [31:0]     wdata_s;
  logic [31:0]     load_s;

  load_align u_load_align (
    .rdata   (mem_rdata),
    .op      (op_r),
    .addr_lo (addr_lo_r),
    .result  (load_s)
  );

  // Byte enables and lane-replicated store data for the incoming request.
  always_comb begin
    be_s    = 4'b1111;
    wdata_s = 32'd0;
    case (req_op)
      OP_SB: begin
        be_s    = 4'b0001 << req_addr[1:0];
        wdata_s = {4{req_wdata[7:0]}};
      end
      OP_SH: begin
        be_s    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_s = {2{req_wdata[15:0]}};
      end
      OP_SW: begin
        be_s    = 4'b1111;
        wdata_s = req_wdata;
      end
      default: begin
        be_s    = 4'b1111;
        wdata_s = 32'd0;
      end
    endcase
  end

  // Sequencer FSM; every output is a register so nothing combinational reaches the ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      op_r      <= 3'd0;
      addr_lo_r <= 2'd0;
      cnt_r     <= {CW{1'b0}};
      req_ready <= 1'b1;
      stall     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= ERR_NONE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_be    <= 4'd0;
      mem_wdata <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            op_r      <= req_op;
            addr_lo_r <= req_addr[1:0];
            req_ready <= 1'b0;
            stall     <= 1'b1;
            if (is_misaligned(req_op, req_addr[1:0])) begin
              state_r   <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= ERR_ALIGN;
              rsp_rdata <= 32'd0;
            end else begin
              state_r   <= ST_ACCESS;
              cnt_r     <= {CW{1'b0}};
              mem_req   <= 1'b1;
              mem_we    <= is_store(req_op);
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_be    <= be_s;
              mem_wdata <= wdata_s;
            end
          end
        end
        ST_ACCESS: begin
          // An ack in the final allowed cycle still completes normally.
          if (mem_ack || (cnt_r == CW'(TIMEOUT - 1))) begin
            state_r   <= ST_RESP;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_be    <= 4'd0;
            mem_wdata <= 32'd0;
            rsp_valid <= 1'b1;
            rsp_err   <= mem_ack ? ERR_NONE : ERR_TIMEOUT;
            rsp_rdata <= (mem_ack && !is_store(op_r)) ? load_s : 32'd0;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_RESP: begin
          state_r   <= ST_IDLE;
          rsp_valid <= 1'b0;
          rsp_rdata <= 32'd0;
          rsp_err   <= ERR_NONE;
          req_ready <= 1'b1;
          stall     <= 1'b0;
        end
        default: begin
          state_r   <= ST_IDLE;
          req_ready <= 1'b1;
          stall     <= 1'b0;
          rsp_valid <= 1'b0;
          mem_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: a driver queues expected responses and
// memory transactions, a memory responder and a response monitor check them.
module tb_mem_access_ctrl;
  import minisys_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        req_ready, stall, rsp_valid, mem_req, mem_we;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata;
  logic [1:0]  rsp_err;
  logic [3:0]  mem_be;

  mem_access_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  function automatic void chk(input bit ok, input string msg);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s", msg);
  endfunction

  typedef struct { logic [31:0] rdata; logic [1:0] err; int at; } rsp_t;
  typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata;
                   logic [31:0] rdata; int delay; } mem_t;

  rsp_t exp_q[$];
  mem_t plan_q[$];

  // ---------------- reference model ----------------
  function automatic int op_size(input logic [2:0] op);
    if (op == 3'd0 || op == 3'd1 || op == 3'd5) return 1;
    if (op == 3'd2 || op == 3'd3 || op == 3'd6) return 2;
    return 4;
  endfunction

  function automatic bit op_store(input logic [2:0] op);
    return op >= 3'd5;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    int k, hk, v;
    logic [7:0]  b;
    logic [15:0] h;
    k  = int'(addr % 4);
    hk = (k / 2) * 2;
    b  = rdata[8*k +: 8];
    h  = rdata[8*hk +: 16];
    case (op)
      3'd0: begin v = $signed(b); return v; end
      3'd1: return {24'd0, b};
      3'd2: begin v = $signed(h); return v; end
      3'd3: return {16'd0, h};
      3'd4: return rdata;
      default: return 32'd0;
    endcase
  endfunction

  // Bytes touched are [addr, addr+size) within the word; loads read the whole word.
  function automatic logic [3:0] ref_be(input logic [2:0] op, input logic [31:0] addr);
    logic [3:0] be;
    int k, sz;
    k = int'(addr % 4);
    sz = op_size(op);
    be = 4'b0000;
    if (!op_store(op)) return 4'b1111;
    for (int i = 0; i < 4; i++) be[i] = (i >= k) && (i < k + sz);
    return be;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] op, input logic [31:0] wd);
    logic [31:0] r;
    int sz;
    sz = op_size(op);
    r = 32'd0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
    return r;
  endfunction

  function automatic bit ref_mis(input logic [2:0] op, input logic [31:0] addr);
    return (addr % op_size(op)) != 0;
  endfunction

  // ---------------- driver ----------------
  task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rd, input int delay,
                       input logic [31:0] exp_rd, input logic [1:0] exp_err);
    int waited;
    bit mis;
    rsp_t r;
    mem_t m;
    waited = 0;
    @(negedge clk);
    while (!req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk(req_ready == 1'b1, $sformatf("ready_wait: req_ready=%0b required 1", req_ready));
    mis = ref_mis(op, addr);
    r.rdata = exp_rd;
    r.err = exp_err;
    r.at = cyc + (mis ? 1 : (delay >= TO ? TO + 1 : delay + 2));
    exp_q.push_back(r);
    if (!mis) begin
      m.addr = {addr[31:2], 2'b00};
      m.we = op_store(op);
      m.be = ref_be(op, addr);
      m.wdata = ref_wdata(op, wd);
      m.rdata = rd;
      m.delay = delay;
      plan_q.push_back(m);
    end
    req_valid = 1'b1;
    req_op = op;
    req_addr = addr;
    req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic issue_rand();
    logic [2:0]  op;
    logic [31:0] addr, wd, rd, erd;
    logic [1:0]  eerr;
    int d;
    op = 3'($urandom_range(0, 7));
    addr = $urandom;
    if ($urandom_range(0, 3) != 0) addr = addr & ~32'(op_size(op) - 1);
    wd = $urandom;
    rd = $urandom;
    d = $urandom_range(0, TO + 1);
    if (ref_mis(op, addr)) begin erd = 32'd0; eerr = 2'd1; end
    else if (d >= TO) begin erd = 32'd0; eerr = 2'd2; end
    else begin erd = op_store(op) ? 32'd0 : ref_load(op, addr, rd); eerr = 2'd0; end
    issue(op, addr, wd, rd, d, erd, eerr);
  endtask

  // ---------------- memory responder ----------------
  mem_t cur;
  bit active = 1'b0;
  int n = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      active = 1'b0;
      mem_ack = 1'b0;
    end else if (mem_req) begin
      if (!active) begin
        chk(plan_q.size() > 0, $sformatf("mem_req_unexpected: mem_req=1 addr=%h required no request", mem_addr));
        if (plan_q.size() > 0) cur = plan_q.pop_front();
        else cur = '{32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 0};
        active = 1'b1;
        n = 0;
      end else begin
        n++;
      end
      chk(mem_addr == cur.addr && mem_we == cur.we && mem_be == cur.be &&
          (!cur.we || mem_wdata == cur.wdata),
          $sformatf("mem_fields: addr=%h we=%0b be=%b wdata=%h required addr=%h we=%0b be=%b wdata=%h",
                    mem_addr, mem_we, mem_be, mem_wdata, cur.addr, cur.we, cur.be, cur.wdata));
      mem_ack = (n == cur.delay);
      mem_rdata = (n == cur.delay) ? cur.rdata : $urandom;
    end else begin
      if (active)
        chk(n + 1 == ((cur.delay + 1 < TO) ? cur.delay + 1 : TO),
            $sformatf("mem_req_cycles: got %0d required %0d", n + 1,
                      (cur.delay + 1 < TO) ? cur.delay + 1 : TO));
      active = 1'b0;
      mem_ack = ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom;
    end
  end

  // ---------------- response monitor ----------------
  rsp_t e;
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, $sformatf("rsp_unexpected: rsp_valid=1 rdata=%h err=%0d required none", rsp_rdata, rsp_err));
        end else begin
          e = exp_q.pop_front();
          chk(rsp_rdata == e.rdata && rsp_err == e.err && cyc == e.at,
              $sformatf("rsp: rdata=%h err=%0d cycle=%0d required rdata=%h err=%0d cycle=%0d",
                        rsp_rdata, rsp_err, cyc, e.rdata, e.err, e.at));
        end
      end else begin
        chk(rsp_rdata == 32'd0 && rsp_err == 2'd0,
            $sformatf("rsp_idle_zero: rdata=%h err=%0d required 0", rsp_rdata, rsp_err));
      end
      chk(stall == !req_ready, $sformatf("stall_ready: stall=%0b req_ready=%0b required opposite", stall, req_ready));
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int waited;
    mem_t m;
    repeat (3) @(negedge clk);
    chk(req_ready == 1'b1 && stall == 1'b0 && rsp_valid == 1'b0 && rsp_rdata == 32'd0 &&
        rsp_err == 2'd0 && mem_req == 1'b0 && mem_we == 1'b0 && mem_addr == 32'd0 &&
        mem_be == 4'd0 && mem_wdata == 32'd0,
        $sformatf("reset_state: ready=%0b stall=%0b rsp_valid=%0b mem_req=%0b be=%b required ready=1 rest 0",
                  req_ready, stall, rsp_valid, mem_req, mem_be));
    rst_n = 1'b1;

    issue(3'd0, 32'h1003, 32'd0, 32'h80FF1234, 0, 32'hFFFFFF80, 2'd0);
    issue(3'd1, 32'h1003, 32'd0, 32'h80FF1234, 0, 32'h00000080, 2'd0);
    issue(3'd2, 32'h2002, 32'd0, 32'h80FF1234, 1, 32'hFFFF80FF, 2'd0);
    issue(3'd3, 32'h2000, 32'd0, 32'h80FF1234, 2, 32'h00001234, 2'd0);
    issue(3'd6, 32'h2002, 32'h0000BEEF, 32'd0, 1, 32'd0, 2'd0);
    issue(3'd5, 32'h2001, 32'h0000005A, 32'd0, 0, 32'd0, 2'd0);
    issue(3'd4, 32'h00000006, 32'd0, 32'h12345678, 0, 32'd0, 2'd1);
    issue(3'd7, 32'h00000004, 32'hCAFEF00D, 32'd0, 2, 32'd0, 2'd0);
    issue(3'd4, 32'h00000010, 32'd0, 32'h11112222, 9, 32'd0, 2'd2);
    issue(3'd4, 32'h00000014, 32'd0, 32'hA5A5C3C3, TO - 1, 32'hA5A5C3C3, 2'd0);

    // Reset while an access is outstanding: no response may follow.
    waited = 0;
    @(negedge clk);
    while (!req_ready && waited < 50) begin @(negedge clk); waited++; end
    m = '{32'h00000100, 1'b0, 4'b1111, 32'd0, 32'd0, 20};
    plan_q.push_back(m);
    req_valid = 1'b1; req_op = 3'd4; req_addr = 32'h100;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 chk(mem_req == 1'b1, $sformatf("pre_reset_access: mem_req=%0b required 1", mem_req));
    #1 rst_n = 1'b0;
    #1 chk(mem_req == 1'b0 && rsp_valid == 1'b0 && stall == 1'b0,
           $sformatf("async_reset: mem_req=%0b rsp_valid=%0b stall=%0b required 0", mem_req, rsp_valid, stall));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk(req_ready == 1'b1 && rsp_valid == 1'b0,
        $sformatf("post_reset: req_ready=%0b rsp_valid=%0b required 1/0", req_ready, rsp_valid));

    issue(3'd4, 32'h00000200, 32'd0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 2'd0);
    issue(3'd7, 32'h00000204, 32'h01020304, 32'd0, 0, 32'd0, 2'd0);

    for (int i = 0; i < 80; i++) issue_rand();

    waited = 0;
    while ((exp_q.size() != 0 || plan_q.size() != 0 || stall) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    chk(exp_q.size() == 0 && plan_q.size() == 0,
        $sformatf("drain: pending rsp=%0d mem=%0d required 0", exp_q.size(), plan_q.size()));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Load/store access sequencer between the execute/memory pipeline stage and the data memory port. Accepts one byte, halfword or word access at a time, checks alignment, drives the word-aligned memory handshake with byte enables, and returns loaded data with byte/halfword lane extraction and sign or zero extension. It holds the pipeline stalled while an access is outstanding and reports misalignment and memory timeout errors.

## Interface
- TIMEOUT, 16, maximum ACCESS cycles without mem_ack before a timeout error (≥1)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  access request from pipeline
- req_ready  out  1  high only in IDLE
- req_op  in  3  LB=0, LBU=1, LH=2, LHU=3, LW=4, SB=5, SH=6, SW=7
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- stall  out  1  high whenever state ≠ IDLE
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  2  0 ok, 1 misaligned, 2 timeout
- mem_req  out  1  memory request, held until ack or timeout
- mem_we  out  1  1 = write
- mem_addr  out  32  {addr[31:2], 2'b00}
- mem_be  out  4  byte enables, bit i = bits [8i+7:8i]
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  memory completion; read data valid same cycle
- mem_rdata  in  32  read data

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset: state IDLE; all outputs 0 except req_ready=1.
- IDLE: request is accepted when req_valid=1 (req_ready=1); op, addr and wdata are registered.
- Misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0): go to RESP with err=1. No mem_req is issued.
- Aligned: go to ACCESS. Wait counter is cleared.
- ACCESS: mem_req=1 and mem_we/addr/be/wdata stay stable. The counter increments each cycle.
  - mem_ack=1: capture data, go to RESP with err=0. mem_req drops in the next cycle.
  - No ack with counter = TIMEOUT-1: go to RESP with err=2.
  - If ack and timeout occur in the same cycle, the ack takes priority.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. rsp_rdata and rsp_err are valid only while rsp_valid=1 and are 0 otherwise.
- Byte lanes are little-endian. k = addr[1:0].
- Stores:
  - SB: be = 1<<k; wdata = {4{wdata[7:0]}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{wdata[15:0]}}.
  - SW: be = 4'b1111.
- Loads: be = 4'b1111.
  - Byte = rdata[8k+7:8k]; halfword = rdata[16·addr[1]+15 : 16·addr[1]].
  - LB/LH replicate the MSB into the upper bits (sign extension). LBU/LHU zero-fill. LW passes rdata through.
- mem_ack outside ACCESS is ignored.
- Reset mid-access: mem_req drops immediately (asynchronously), the captured request is discarded, and no rsp_valid is produced.

## Timing
- Request accepted at cycle 0 (req_valid & req_ready).
- mem_req first high at cycle 1.
- Ack in cycle N ≥ 1: rsp_valid at N+1, IDLE at N+2, so next accept is possible at N+2.
- Minimum load/store latency (ack in first ACCESS cycle) is 2 cycles to rsp_valid.
- Misaligned: rsp_valid at cycle 1, never any mem_req.
- Timeout: mem_req high for cycles 1..TIMEOUT, rsp_valid (err=2) at TIMEOUT+1.
- All outputs are registered. There is no combinational path from inputs to mem_* or rsp_*.

## Structure
- Shared package minisys_pkg holds:
  - the req_op encodings (OP_LB … OP_SW);
  - the error codes (ERR_NONE/ERR_ALIGN/ERR_TIMEOUT);
  - the state enum.
- One combinational sub-module, load_align, takes (rdata, op, addr[1:0]) and returns the lane-selected, extended 32-bit load result.
- Store lane replication and byte-enable generation stay inline.

## Test plan
- LB addr 0x1003, mem_rdata 0x80FF1234, ack at cycle 1 -> rsp_rdata 0xFFFFFF80, err 0, rsp_valid at cycle 2. LBU with the same data -> 0x00000080.
- LH addr 0x2002, mem_rdata 0x80FF1234 -> 0xFFFF80FF. LHU addr 0x2000 -> 0x00001234. mem_addr is 0x2000 in both cases.
- SH addr 0x2002, wdata 0x0000BEEF -> mem_we 1, mem_be 4'b1100, mem_wdata 0xBEEFBEEF. SB addr 0x2001, wdata 0x5A -> be 4'b0010, mem_wdata 0x5A5A5A5A.
- LW addr 0x6 -> rsp_valid at cycle 1, err 1, rdata 0, mem_req never asserted. SW addr 0x4 -> be 4'b1111.
- TIMEOUT=4, no ack -> mem_req high cycles 1–4, rsp err 2 at cycle 5. A second run with ack arriving at cycle 4 -> err 0 (ack wins).
- rst_n low during ACCESS -> mem_req 0 immediately, no rsp_valid, req_ready 1 after release. A back-to-back LW then SW completes with no dropped or duplicated rsp_valid.
